// File: rtl/referee_merge.sv
// referee_merge: four-to-one round-robin merge arbiter.
// Drains four class FIFOs (registered read port) into one downstream FIFO,
// one word per cycle, throttled by the downstream almost_full flag.
//
// Ports:
//   clk_i            rising-edge clock
//   reset_i          synchronous active-high reset
//   empty_k_i        empty flag of class FIFO k (k = 0..3)
//   data_in_k_i      read data of class FIFO k, valid the cycle after pop_k_o
//   almost_full_i    downstream almost-full; suppresses pops in the same cycle
//   pop_k_o          read strobe to class FIFO k (at most one per cycle)
//   push_o           registered write strobe to the downstream FIFO
//   data_out_o       registered write data, valid when push_o = 1
//   idle_o           no word in flight and all class FIFOs empty
module referee_merge #(
  parameter int unsigned DataWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 empty_0_i,
  input  logic                 empty_1_i,
  input  logic                 empty_2_i,
  input  logic                 empty_3_i,
  input  logic [DataWidth-1:0] data_in_0_i,
  input  logic [DataWidth-1:0] data_in_1_i,
  input  logic [DataWidth-1:0] data_in_2_i,
  input  logic [DataWidth-1:0] data_in_3_i,
  input  logic                 almost_full_i,
  output logic                 pop_0_o,
  output logic                 pop_1_o,
  output logic                 pop_2_o,
  output logic                 pop_3_o,
  output logic                 push_o,
  output logic [DataWidth-1:0] data_out_o,
  output logic                 idle_o
);

  typedef enum logic [1:0] {StReset, StInit, StIdle, StActive} state_e;

  state_e               state_q;
  logic [1:0]           last_grant_q;
  logic [1:0]           sel_q;
  logic                 pend_q;
  logic                 push_q;
  logic [DataWidth-1:0] data_out_q;

  logic [3:0]           empty;
  logic                 all_empty;
  logic                 grant_valid;
  logic [1:0]           grant_idx;
  logic [1:0]           cand;
  logic [3:0]           pop;
  logic [DataWidth-1:0] sel_data;

  assign empty     = {empty_3_i, empty_2_i, empty_1_i, empty_0_i};
  assign all_empty = &empty;

  // Round-robin search starting one past the last grant. Pops are also held
  // off while reset is asserted so no word is lost to a FIFO being cleared.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    pop         = '0;
    if (!reset_i && !almost_full_i && (state_q == StIdle || state_q == StActive)) begin
      for (int i = 1; i <= 4; i++) begin
        cand = last_grant_q + 2'(i);
        if (!grant_valid && !empty[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
    pop[grant_idx] = grant_valid;
  end

  always_comb begin
    sel_data = data_in_0_i;
    unique case (sel_q)
      2'd0: sel_data = data_in_0_i;
      2'd1: sel_data = data_in_1_i;
      2'd2: sel_data = data_in_2_i;
      2'd3: sel_data = data_in_3_i;
      default: sel_data = data_in_0_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StReset;
      last_grant_q <= 2'd3;
      sel_q        <= 2'd0;
      pend_q       <= 1'b0;
      push_q       <= 1'b0;
      data_out_q   <= '0;
    end else begin
      unique case (state_q)
        StReset:  state_q <= StInit;
        StInit:   state_q <= StIdle;
        StIdle:   if (!all_empty) state_q <= StActive;
        StActive: if (all_empty) state_q <= StIdle;
        default:  state_q <= StReset;
      endcase
      if (grant_valid) begin
        last_grant_q <= grant_idx;
        sel_q        <= grant_idx;
      end
      pend_q <= grant_valid;
      // FIFO read data is valid the cycle after the pop, when pend_q is set.
      push_q <= pend_q;
      if (pend_q) data_out_q <= sel_data;
    end
  end

  assign pop_0_o    = pop[0];
  assign pop_1_o    = pop[1];
  assign pop_2_o    = pop[2];
  assign pop_3_o    = pop[3];
  assign push_o     = push_q;
  assign data_out_o = data_out_q;
  assign idle_o     = all_empty & ~pend_q & ~push_q;

endmodule

// File: tb/tb_referee_merge.sv
// Directed testbench for referee_merge with behavioural class FIFOs
// (registered read port) and a posedge monitor logging pops and pushes.
module tb_referee_merge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        almost_full = 1'b0;
  logic [3:0]  emp = 4'hF;
  logic [11:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;
  logic        pop0, pop1, pop2, pop3, push, idle;
  logic [11:0] data_out;
  logic [3:0]  popv;

  logic [11:0] q0[$], q1[$], q2[$], q3[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int viol    = 0;
  int af_pops = 0;
  int          pop_cls[$];
  int          pop_cyc[$];
  logic [11:0] push_dat[$];
  int          push_cyc[$];

  always #5 clk = ~clk;

  assign popv = {pop3, pop2, pop1, pop0};

  referee_merge #(.DataWidth(12)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .empty_0_i     (emp[0]),
    .empty_1_i     (emp[1]),
    .empty_2_i     (emp[2]),
    .empty_3_i     (emp[3]),
    .data_in_0_i   (din0),
    .data_in_1_i   (din1),
    .data_in_2_i   (din2),
    .data_in_3_i   (din3),
    .almost_full_i (almost_full),
    .pop_0_o       (pop0),
    .pop_1_o       (pop1),
    .pop_2_o       (pop2),
    .pop_3_o       (pop3),
    .push_o        (push),
    .data_out_o    (data_out),
    .idle_o        (idle)
  );

  // Class FIFO model: read data registered on the pop edge.
  initial begin
    forever begin
      @(posedge clk);
      if (popv[0] && q0.size() > 0) din0 <= q0.pop_front();
      if (popv[1] && q1.size() > 0) din1 <= q1.pop_front();
      if (popv[2] && q2.size() > 0) din2 <= q2.pop_front();
      if (popv[3] && q3.size() > 0) din3 <= q3.pop_front();
      emp <= {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    end
  end

  // Monitor: samples the values in effect for the cycle ending at this edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 4; k++) begin
        if (popv[k]) begin
          pop_cls.push_back(k);
          pop_cyc.push_back(cyc);
        end
      end
      if (|popv && almost_full) af_pops++;
      if ($countones(popv) > 1) viol++;
      if ((popv & emp) != 4'h0) viol++;
      if (push) begin
        push_dat.push_back(data_out);
        push_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int k, input logic [11:0] w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  task automatic clear_logs();
    pop_cls.delete();
    pop_cyc.delete();
    push_dat.delete();
    push_cyc.delete();
  endtask

  task automatic wait_pop(input int k, input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 30 && ok == 0; i++) begin
      @(negedge clk);
      if (popv[k]) ok = 1;
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int rel;
    int gaps;

    // Reset held 3 cycles, all class FIFOs empty.
    repeat (3) @(negedge clk);
    check("rst_pop", 32'(popv), 0);
    check("rst_push", 32'(push), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_lastgrant", 32'(dut.last_grant_q), 3);
    check("rst_state", 32'(dut.state_q), 0);
    reset = 1'b0;
    @(negedge clk);
    check("init_state", 32'(dut.state_q), 1);
    @(negedge clk);
    check("idle_state", 32'(dut.state_q), 2);
    clear_logs();
    repeat (3) @(negedge clk);
    check("quiet_pops", pop_cls.size(), 0);
    check("quiet_idle", 32'(idle), 1);

    // Single class with two words.
    clear_logs();
    load(2, 12'h0A1);
    load(2, 12'h0A2);
    repeat (8) @(negedge clk);
    check("c2_npop", pop_cls.size(), 2);
    check("c2_cls0", pop_cls[0], 2);
    check("c2_cls1", pop_cls[1], 2);
    check("c2_b2b", pop_cyc[1] - pop_cyc[0], 1);
    check("c2_npush", push_dat.size(), 2);
    check("c2_d0", 32'(push_dat[0]), 32'h0A1);
    check("c2_d1", 32'(push_dat[1]), 32'h0A2);
    check("c2_lat", push_cyc[0] - pop_cyc[0], 2);
    check("c2_idle", 32'(idle), 1);

    // Reset so the pointer starts at 3, then all four classes, 3 words each.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) load(k, 12'((k << 8) | i));
    end
    repeat (20) @(negedge clk);
    check("rr_npop", pop_cls.size(), 12);
    check("rr_npush", push_dat.size(), 12);
    gaps = 0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("rr_cls%0d", i), pop_cls[i], i % 4);
      check($sformatf("rr_dat%0d", i), 32'(push_dat[i]), ((i % 4) << 8) | (i / 4));
      if (push_cyc[i] != push_cyc[0] + i) gaps++;
    end
    check("rr_gaps", gaps, 0);

    // Stall: almost_full rises the cycle after a pop_0.
    clear_logs();
    load(0, 12'h0B1);
    load(0, 12'h0B2);
    load(3, 12'h3C1);
    wait_pop(0, "af_wait_pop0");
    @(posedge clk);
    #1 almost_full = 1'b1;
    repeat (4) @(negedge clk);
    check("af_npush_stalled", push_dat.size(), 1);
    check("af_word_pushed", 32'(push_dat[0]), 32'h0B1);
    check("af_npop_stalled", pop_cls.size(), 1);
    almost_full = 1'b0;
    repeat (8) @(negedge clk);
    check("af_pops_during", af_pops, 0);
    check("af_npop", pop_cls.size(), 3);
    check("af_next_is_3", pop_cls[1], 3);
    check("af_third_is_0", pop_cls[2], 0);
    check("af_d1", 32'(push_dat[1]), 32'h3C1);
    check("af_d2", 32'(push_dat[2]), 32'h0B2);

    // Reset pulse in the cycle after pop_1: in-flight word dropped.
    clear_logs();
    load(1, 12'h1D1);
    load(2, 12'h2D2);
    load(3, 12'h3D3);
    wait_pop(1, "rp_wait_pop1");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    check("rp_lastgrant", 32'(dut.last_grant_q), 3);
    check("rp_push_now", 32'(push), 0);
    repeat (10) @(negedge clk);
    check("rp_npop", pop_cls.size(), 3);
    check("rp_first_after", pop_cls[1], 2);
    check("rp_first_cyc", pop_cyc[1] - rel, 3);
    check("rp_npush", push_dat.size(), 2);
    check("rp_d0", 32'(push_dat[0]), 32'h2D2);
    check("rp_d1", 32'(push_dat[1]), 32'h3D3);

    // Class 1 holds one word and then empties.
    clear_logs();
    load(1, 12'h1E1);
    repeat (8) @(negedge clk);
    check("one_npop", pop_cls.size(), 1);
    check("one_cls", pop_cls[0], 1);
    check("one_npush", push_dat.size(), 1);
    check("one_dat", 32'(push_dat[0]), 32'h1E1);
    check("one_idle", 32'(idle), 1);
    check("pop_rule_viol", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
